// File: rtl/face_matrix_player_if.sv
// Signal bundle between the game controller and the end-of-game face player.
// The controller side (master) raises fail/win and watches repeatRst/busy;
// the player side (slave) drives the matrix rows/columns and the buzzer.
interface face_matrix_player_if;
  logic       fail;
  logic       win;
  logic [7:0] hang;
  logic [7:0] red;
  logic [7:0] green;
  logic       beep;
  logic       repeatRst;
  logic       busy;

  modport master (
    output fail, win,
    input  hang, red, green, beep, repeatRst, busy
  );

  modport slave (
    input  fail, win,
    output hang, red, green, beep, repeatRst, busy
  );
endinterface

// File: rtl/face_matrix_player.sv
// End-of-game display and sound block.
// On a fail/win trigger it scans a crying (red) or smiley (green) face onto
// the 8x8 matrix, plays a mode-dependent square wave on the buzzer, and after
// HOLD_CYCLES raises repeatRst until the controller drops both triggers.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | matrix blank, waiting for fail or win
// SHOW  | face scanned row by row, tone running, hold counter advancing
// DONE  | matrix blank, repeatRst high until fail and win are both low
module face_matrix_player #(
  parameter int SCAN_DIV       = 1,
  parameter int TONE_FAIL      = 11,
  parameter int TONE_WIN       = 5,
  parameter int HOLD_CYCLES    = 501,
  parameter bit ROW_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  face_matrix_player_if.slave  bus
);

  // Counter widths hold the parameter value itself, so the terminal compares
  // below (param-1) always fit and no counter can wrap.
  localparam int TONE_MAX = (TONE_FAIL > TONE_WIN) ? TONE_FAIL : TONE_WIN;
  localparam int SW       = $clog2(SCAN_DIV + 1);
  localparam int TW       = $clog2(TONE_MAX + 1);
  localparam int HW       = $clog2(HOLD_CYCLES + 1);

  localparam logic [SW-1:0] SCAN_LAST      = SW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] TONE_FAIL_LAST = TW'(TONE_FAIL - 1);
  localparam logic [TW-1:0] TONE_WIN_LAST  = TW'(TONE_WIN - 1);
  localparam logic [HW-1:0] HOLD_LAST      = HW'(HOLD_CYCLES - 1);

  localparam logic [7:0] HANG_IDLE = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_mode;      // 1 = fail (crying face), 0 = win (smiley)
  logic [2:0]    r_row;
  logic [SW-1:0] r_scan_cnt;
  logic [TW-1:0] r_tone_cnt;
  logic [HW-1:0] r_hold_cnt;

  logic [7:0]    r_hang;
  logic [7:0]    r_red;
  logic [7:0]    r_green;
  logic          r_beep;
  logic          r_repeat_rst;
  logic          r_busy;

  logic          w_trig;
  logic          w_scan_wrap;
  logic [2:0]    w_row_next;
  logic [TW-1:0] w_tone_last;

  // Crying face, row 0 at the top.
  function automatic logic [7:0] fail_row(input logic [2:0] i_row);
    logic [7:0] v;
    case (i_row)
      3'd0:    v = 8'h81;
      3'd1:    v = 8'h42;
      3'd2:    v = 8'h24;
      3'd3:    v = 8'h42;
      3'd4:    v = 8'h81;
      3'd5:    v = 8'h18;
      3'd6:    v = 8'h24;
      default: v = 8'h42;
    endcase
    return v;
  endfunction

  // Smiley face, row 0 at the top.
  function automatic logic [7:0] win_row(input logic [2:0] i_row);
    logic [7:0] v;
    case (i_row)
      3'd0:    v = 8'h00;
      3'd1:    v = 8'h66;
      3'd2:    v = 8'h66;
      3'd3:    v = 8'h00;
      3'd4:    v = 8'h81;
      3'd5:    v = 8'h42;
      3'd6:    v = 8'h3C;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Row 0 sits on hang[7]; only the selected row carries the active level.
  function automatic logic [7:0] row_sel(input logic [2:0] i_row);
    logic [7:0] s;
    s = 8'h80 >> i_row;
    return ROW_ACTIVE_LOW ? ~s : s;
  endfunction

  // Next-row and tone-period selection shared by the SHOW branch.
  assign w_trig      = bus.fail | bus.win;
  assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);
  assign w_row_next  = w_scan_wrap ? (r_row + 3'd1) : r_row;
  assign w_tone_last = r_mode ? TONE_FAIL_LAST : TONE_WIN_LAST;

  // Sequencer: state, counters and all registered outputs in one place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b0;
      r_row        <= '0;
      r_scan_cnt   <= '0;
      r_tone_cnt   <= '0;
      r_hold_cnt   <= '0;
      r_hang       <= HANG_IDLE;
      r_red        <= 8'h00;
      r_green      <= 8'h00;
      r_beep       <= 1'b0;
      r_repeat_rst <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            // Fail wins a tie; mode stays frozen for the whole sequence.
            r_state      <= S_SHOW;
            r_mode       <= bus.fail;
            r_row        <= '0;
            r_scan_cnt   <= '0;
            r_tone_cnt   <= '0;
            r_hold_cnt   <= '0;
            r_hang       <= row_sel(3'd0);
            r_red        <= bus.fail ? fail_row(3'd0) : 8'h00;
            r_green      <= bus.fail ? 8'h00 : win_row(3'd0);
            r_beep       <= 1'b0;
            r_repeat_rst <= 1'b0;
            r_busy       <= 1'b1;
          end
        end

        S_SHOW: begin
          if (r_hold_cnt == HOLD_LAST) begin
            // Hold time used up; blank the matrix and ask for a restart.
            r_state      <= S_DONE;
            r_row        <= '0;
            r_scan_cnt   <= '0;
            r_tone_cnt   <= '0;
            r_hold_cnt   <= '0;
            r_hang       <= HANG_IDLE;
            r_red        <= 8'h00;
            r_green      <= 8'h00;
            r_beep       <= 1'b0;
            r_repeat_rst <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;

            r_scan_cnt <= w_scan_wrap ? '0 : (r_scan_cnt + 1'b1);
            r_row      <= w_row_next;
            r_hang     <= row_sel(w_row_next);
            r_red      <= r_mode ? fail_row(w_row_next) : 8'h00;
            r_green    <= r_mode ? 8'h00 : win_row(w_row_next);

            if (r_tone_cnt == w_tone_last) begin
              r_tone_cnt <= '0;
              r_beep     <= ~r_beep;
            end else begin
              r_tone_cnt <= r_tone_cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          // Triggers dropping is the controller's acknowledgement of repeatRst.
          if (!w_trig) begin
            r_state      <= S_IDLE;
            r_repeat_rst <= 1'b0;
            r_busy       <= 1'b0;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_hang       <= HANG_IDLE;
          r_red        <= 8'h00;
          r_green      <= 8'h00;
          r_beep       <= 1'b0;
          r_repeat_rst <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hang      = r_hang;
  assign bus.red       = r_red;
  assign bus.green     = r_green;
  assign bus.beep      = r_beep;
  assign bus.repeatRst = r_repeat_rst;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_face_matrix_player.sv
// Bench for face_matrix_player: two instances (defaults, and a fast
// non-inverted variant) checked every cycle against a cycle-count model.
module tb_face_matrix_player;

  logic clk;
  logic rst_a;
  logic rst_b;

  face_matrix_player_if ifa ();
  face_matrix_player_if ifb ();

  face_matrix_player dut_a (
    .clk   (clk),
    .rst_n (rst_a),
    .bus   (ifa.slave)
  );

  face_matrix_player #(
    .SCAN_DIV       (2),
    .TONE_FAIL      (3),
    .TONE_WIN       (5),
    .HOLD_CYCLES    (40),
    .ROW_ACTIVE_LOW (1'b0)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_b),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance parameters seen by the model.
  int sd [2] = '{1, 2};
  int tf [2] = '{11, 3};
  int tw [2] = '{5, 5};
  int hc [2] = '{501, 40};
  bit al [2] = '{1'b1, 1'b0};

  logic [7:0] fp [8] = '{8'h81, 8'h42, 8'h24, 8'h42, 8'h81, 8'h18, 8'h24, 8'h42};
  logic [7:0] wp [8] = '{8'h00, 8'h66, 8'h66, 8'h00, 8'h81, 8'h42, 8'h3C, 8'h00};

  // Model: phase 0 idle, 1 showing, 2 waiting for triggers to drop.
  int ph [2] = '{0, 0};
  bit md [2] = '{1'b0, 1'b0};
  int jc [2] = '{0, 0};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int d, input logic rst, input logic f, input logic w);
    if (!rst) begin
      ph[d] = 0;
    end else begin
      case (ph[d])
        0: if (f || w) begin ph[d] = 1; md[d] = f; jc[d] = 0; end
        1: begin
          jc[d]++;
          if (jc[d] == hc[d]) ph[d] = 2;
        end
        default: if (!f && !w) ph[d] = 0;
      endcase
    end
  endtask

  task automatic chk_dut(input int d, input logic [7:0] h, input logic [7:0] rd,
                         input logic [7:0] gr, input logic bp, input logic rr, input logic bz);
    logic [7:0] eh, er, eg, sel;
    logic       eb, err, ebz;
    int         r;
    string      n;
    n   = (d == 0) ? "A" : "B";
    eh  = al[d] ? 8'hFF : 8'h00;
    er  = 8'h00;
    eg  = 8'h00;
    eb  = 1'b0;
    err = 1'b0;
    ebz = 1'b0;
    if (ph[d] == 1) begin
      r   = (jc[d] / sd[d]) % 8;
      sel = 8'h80 >> r;
      eh  = al[d] ? ~sel : sel;
      if (md[d]) er = fp[r];
      else       eg = wp[r];
      eb  = ((jc[d] / (md[d] ? tf[d] : tw[d])) % 2) == 1;
      ebz = 1'b1;
    end else if (ph[d] == 2) begin
      err = 1'b1;
      ebz = 1'b1;
    end
    check({n, ".hang"}, h, eh);
    check({n, ".red"}, rd, er);
    check({n, ".green"}, gr, eg);
    check({n, ".beep"}, {7'd0, bp}, {7'd0, eb});
    check({n, ".repeatRst"}, {7'd0, rr}, {7'd0, err});
    check({n, ".busy"}, {7'd0, bz}, {7'd0, ebz});
  endtask

  task automatic chk_all();
    chk_dut(0, ifa.hang, ifa.red, ifa.green, ifa.beep, ifa.repeatRst, ifa.busy);
    chk_dut(1, ifb.hang, ifb.red, ifb.green, ifb.beep, ifb.repeatRst, ifb.busy);
  endtask

  // One clock: both DUTs and the model see the same inputs at the edge.
  task automatic step();
    @(posedge clk);
    model_edge(0, rst_a, ifa.fail, ifa.win);
    model_edge(1, rst_b, ifb.fail, ifb.win);
    #1;
    chk_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int drop_at;
    rst_a    = 1'b0;
    rst_b    = 1'b0;
    ifa.fail = 1'b0;
    ifa.win  = 1'b0;
    ifb.fail = 1'b0;
    ifb.win  = 1'b0;

    // Reset and idle values.
    run(3);
    rst_a = 1'b1;
    rst_b = 1'b1;
    run(3);

    // A: fail sequence, then hold fail 20 cycles past repeatRst, then drop.
    ifa.fail = 1'b1;
    run(1 + 501 + 20);
    ifa.fail = 1'b0;
    run(3);

    // B: win sequence with 2-cycle rows, non-inverted row select.
    ifb.win = 1'b1;
    run(1 + 40 + 2);
    ifb.win = 1'b0;
    run(2);

    // B: fail sequence.
    ifb.fail = 1'b1;
    run(1 + 40 + 1);
    ifb.fail = 1'b0;
    run(2);

    // A: both triggers on the same edge, win jitters mid-show,
    // both triggers dropped at a random point; sequence must still finish.
    drop_at  = int'($urandom_range(50, 400));
    ifa.fail = 1'b1;
    ifa.win  = 1'b1;
    step();
    for (int i = 0; i < 510; i++) begin
      if (i < drop_at) begin
        ifa.win = 1'($urandom_range(0, 1));
      end else begin
        ifa.win  = 1'b0;
        ifa.fail = 1'b0;
      end
      step();
    end
    run(2);

    // A: reset pulse at cycle 137 of SHOW, checked before any clock edge.
    ifa.fail = 1'b1;
    step();
    run(137);
    rst_a = 1'b0;
    ph[0] = 0;
    #1;
    chk_all();
    run(1);
    rst_a = 1'b1;
    run(1 + 501 + 3);
    ifa.fail = 1'b0;
    run(3);

    // Random trigger activity on both instances.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) ifa.fail = ~ifa.fail;
      if ($urandom_range(0, 39) == 0) ifa.win  = ~ifa.win;
      if ($urandom_range(0, 19) == 0) ifb.fail = ~ifb.fail;
      if ($urandom_range(0, 19) == 0) ifb.win  = ~ifb.win;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/face_matrix_player.md
# face_matrix_player

Parametrised end-of-game display and sound block for the bomb-dismantlement game. On a `fail` or `win` trigger it does three things:
- scans a fixed 8x8 face pattern onto the dot matrix: red crying face on fail, green smiley on win;
- drives the buzzer with a mode-dependent square wave;
- after a programmable hold time, asserts `repeatRst` to restart the game.

It sits between the game-control FSM and the matrix/buzzer pins, and supersedes the single-mode crying-face driver.

## Interface
Parameters:
- `SCAN_DIV`, 1: clock cycles each row stays selected (>=1).
- `TONE_FAIL`, 11: beep half-period in cycles, fail mode (>=1).
- `TONE_WIN`, 5: beep half-period in cycles, win mode (>=1).
- `HOLD_CYCLES`, 501: cycles the face is shown before `repeatRst` (>=1).
- `ROW_ACTIVE_LOW`, 1: 1 = selected row driven 0 on `hang`; 0 = driven 1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fail`  in  1  level; request crying-face sequence.
- `win`  in  1  level; request smiley sequence.
- `hang`  out  8  row select; bit 7 = row 0.
- `red`  out  8  red column data for the selected row.
- `green`  out  8  green column data for the selected row.
- `beep`  out  1  buzzer square wave.
- `repeatRst`  out  1  game-restart request.
- `busy`  out  1  high in SHOW and DONE.

## Operation
- **Idle output values.** Reset and IDLE values:
  - `hang` = all rows deselected: 8'hFF if `ROW_ACTIVE_LOW`, else 8'h00.
  - `red`, `green`, `beep`, `repeatRst`, `busy` = 0.
  - Internal counters = 0.
- **States.** IDLE, SHOW, DONE. All outputs are registered.
- **IDLE -> SHOW.** Taken when `fail` or `win` is high.
  - `mode` is latched: fail (1) if `fail` is high, otherwise win. Fail has priority when both are high.
  - `mode` is not re-sampled during SHOW.
- **SHOW, row scan.**
  - Row index `r` starts at 0 and advances every `SCAN_DIV` cycles, wrapping 7 -> 0.
  - `hang` selects only row `r`: bit 7-`r` is active, all other bits inactive.
- **SHOW, column data.** The active colour gets the row pattern; the other colour is 0.
  - Fail pattern on `red`, rows 0..7: 81, 42, 24, 42, 81, 18, 24, 42 (hex).
  - Win pattern on `green`, rows 0..7: 00, 66, 66, 00, 81, 42, 3C, 00 (hex).
- **SHOW, tone.** `beep` toggles every `TONE_FAIL` (fail) or `TONE_WIN` (win) cycles. The tone counter restarts on SHOW entry.
- **SHOW -> DONE.** A hold counter counts SHOW cycles; the transition occurs when it reaches `HOLD_CYCLES`.
- **DONE.**
  - `repeatRst` = 1; matrix blanked to idle values; `beep` = 0.
  - Exits to IDLE once both `fail` and `win` are low. The game controller clears them in response to `repeatRst`.
- **Trigger drop.** If `fail` and `win` both drop during SHOW, the sequence still completes. It is not aborted.
- **Counter widths.** Counters are sized as $clog2(param+1). No counter may overflow for any legal parameter value.

## Timing
- **Edge 0 = first rising edge with a trigger high in IDLE.**
  - After edge 0: `busy` = 1, row 0 displayed, `beep` = 0.
- **Rows.** Row `k` is displayed during cycles k·`SCAN_DIV` .. (k+1)·`SCAN_DIV`-1 after entry, modulo 8·`SCAN_DIV`.
- **First beep edge.** `beep` first rises `T` cycles after entry, where `T` is the active tone half-period.
- **Hold.** SHOW lasts exactly `HOLD_CYCLES` cycles. `repeatRst` rises on the next edge and holds at least 1 cycle.
- **DONE exit.** `repeatRst` falls, and `busy` falls, one cycle after the edge on which both triggers are sampled low.
- **Reset.** `rst_n` low at any time forces all outputs to their reset values immediately (asynchronous). Operation resumes in IDLE on the first edge after deassertion.

## Test plan
- **Fail sequence.** Reset, then `fail`=1 with `SCAN_DIV`=1 and defaults.
  - Rows in order: `hang` 7F,BF,DF,EF,F7,FB,FD,FE with `red` 81,42,24,42,81,18,24,42; `green`=0.
  - `beep` toggles every 11 cycles.
  - `repeatRst`=1 after 501 cycles.
- **Win sequence.** `win`=1, `SCAN_DIV`=2.
  - Each row held 2 cycles; `green` 00,66,66,00,81,42,3C,00; `red`=0.
  - `beep` period 10 cycles.
- **Simultaneous triggers.** `fail` and `win` asserted on the same edge -> fail mode. Toggling `win` mid-SHOW does not change `red`/`green`.
- **DONE handshake.** Hold `fail`=1 for 20 cycles after `repeatRst` -> `repeatRst` stays 1 and the display stays blank. Drop `fail` -> `repeatRst`=0 and `busy`=0 one cycle later.
- **Reset mid-operation.** Pulse `rst_n` low at cycle 137 of SHOW.
  - Outputs: `hang`=FF, `red`=`green`=0, `beep`=0 without waiting for a clock edge.
  - With `fail` still high, re-entry restarts from row 0 and the full hold count.
- **Row polarity.** `ROW_ACTIVE_LOW`=0 -> idle `hang`=00; rows go 80,40,..,01.
